// File: rtl/joint_stepper_pkg.sv
// Shared types and elaboration helpers for the timed single-joint step/dir generator.
package joint_stepper_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, PULSE, LOW} state_t;

   // Shortest period that still leaves the full DIR hold window after every pulse.
   function automatic int unsigned min_period(input int unsigned pulse_len,
                                              input int unsigned dir_hold);
      return pulse_len + dir_hold;
   endfunction

   function automatic bit pulse_len_ok(input int unsigned pulse_len);
      return pulse_len >= 1;
   endfunction

endpackage

// File: rtl/joint_cmd_abs.sv
// Saturating magnitude and sign decode of the signed period command.
module joint_cmd_abs #(
   parameter int unsigned WIDTH = 32
) (
   input  logic signed [WIDTH-1:0] cmd,
   output logic        [WIDTH-1:0] mag,
   output logic                    pos,
   output logic                    nonzero
);

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

   logic [WIDTH-1:0] raw;

   assign raw     = cmd;
   assign nonzero = |raw;
   assign pos     = !raw[WIDTH-1] && nonzero;

   always_comb begin
      mag = raw;
      if (raw[WIDTH-1]) begin
         // The most negative value has no positive twin; clamp it.
         mag = (raw == MOST_NEG) ? MOST_POS : (~raw + ONE);
      end
   end

endmodule

// File: rtl/joint_stepper_timed.sv
// Step/direction generator for one joint with DIR setup/hold timing, fixed-width pulses,
// period clamping and a step-count position feedback.
module joint_stepper_timed
   import joint_stepper_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned PULSE_LEN = 50,
   parameter int unsigned DIR_SETUP = 25,
   parameter int unsigned DIR_HOLD  = 25,
   parameter bit          STP_INV   = 1'b0,
   parameter bit          DIR_INV   = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    jointEnable,
   input  logic signed [WIDTH-1:0] jointFreqCmd,
   output logic signed [WIDTH-1:0] jointFeedback,
   output logic                    jointBusy,
   output logic                    DIR,
   output logic                    STP
);

   if (!pulse_len_ok(PULSE_LEN)) begin : gen_bad_pulse_len
      $error("joint_stepper_timed: PULSE_LEN must be at least 1");
   end

   localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
   localparam logic [WIDTH-1:0] PLEN      = WIDTH'(PULSE_LEN);
   localparam logic [WIDTH-1:0] SETUP_LEN = WIDTH'(DIR_SETUP);
   localparam logic [WIDTH-1:0] HOLD_LEN  = WIDTH'(DIR_HOLD);
   localparam logic [WIDTH-1:0] MIN_T     = WIDTH'(min_period(PULSE_LEN, DIR_HOLD));

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] t_q, t_d;
   logic [WIDTH-1:0] fb_q, fb_d;
   logic             dir_q, dir_d;
   logic             step_q, busy_q;

   logic [WIDTH-1:0] cmd_mag, t_cmd, cnt_inc, low_len;
   logic             cmd_pos, cmd_nz, stop_req, low_done;
   logic             go_eval, start_pulse;

   joint_cmd_abs #(
      .WIDTH (WIDTH)
   ) u_cmd_abs (
      .cmd     (jointFreqCmd),
      .mag     (cmd_mag),
      .pos     (cmd_pos),
      .nonzero (cmd_nz)
   );

   assign t_cmd    = (cmd_mag < MIN_T) ? MIN_T : cmd_mag;
   assign stop_req = !jointEnable || !cmd_nz;
   assign cnt_inc  = cnt_q + ONE;
   assign low_len  = t_q - PLEN;
   // Disabling cuts LOW short, but never below the DIR hold window.
   assign low_done = (cnt_inc == low_len) || (!jointEnable && (cnt_inc >= HOLD_LEN));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_inc;
      t_d         = t_q;
      dir_d       = dir_q;
      fb_d        = fb_q;
      go_eval     = 1'b0;
      start_pulse = 1'b0;

      unique case (state_q)
         IDLE: go_eval = 1'b1;
         SETUP: begin
            if (stop_req) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cmd_pos != dir_q) begin
               dir_d = cmd_pos;
               cnt_d = '0;
            end else if (cnt_inc == SETUP_LEN) begin
               start_pulse = 1'b1;
            end
         end
         PULSE: begin
            if (cnt_inc == PLEN) begin
               if (low_len == '0) begin
                  go_eval = 1'b1;
               end else begin
                  state_d = LOW;
                  cnt_d   = '0;
               end
            end
         end
         LOW: if (low_done) go_eval = 1'b1;
         default: state_d = IDLE;
      endcase

      // Period boundary: same decision as from IDLE.
      if (go_eval) begin
         cnt_d = '0;
         if (stop_req) begin
            state_d = IDLE;
         end else if ((cmd_pos == dir_q) || (DIR_SETUP == 0)) begin
            dir_d       = cmd_pos;
            start_pulse = 1'b1;
         end else begin
            dir_d   = cmd_pos;
            state_d = SETUP;
         end
      end

      if (start_pulse) begin
         state_d = PULSE;
         cnt_d   = '0;
         t_d     = t_cmd;
         fb_d    = dir_d ? (fb_q + ONE) : (fb_q - ONE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         t_q     <= '0;
         fb_q    <= '0;
         dir_q   <= 1'b0;
         step_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         t_q     <= t_d;
         fb_q    <= fb_d;
         dir_q   <= dir_d;
         step_q  <= (state_d == PULSE);
         busy_q  <= (state_d != IDLE);
      end
   end

   assign jointFeedback = fb_q;
   assign jointBusy     = busy_q;
   assign STP           = step_q ^ STP_INV;
   assign DIR           = dir_q ^ DIR_INV;

endmodule

// File: tb/tb_joint_stepper_timed.sv
// Self-checking bench: timeline model of the stepper plus directed scenarios.
module tb_joint_stepper_timed;

   localparam int PL = 2;
   localparam int DS = 3;
   localparam int DH = 2;

   logic               clk = 1'b0;
   logic               rst_n = 1'b1;
   logic               en = 1'b0;
   logic signed [31:0] cmd = '0;
   logic signed [31:0] fb, fb_i;
   logic               busy, dir, stp;
   logic               busy_i, dir_i, stp_i;
   bit                 clk_run = 1'b0;
   bit                 checking = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   joint_stepper_timed #(
      .WIDTH(32), .PULSE_LEN(PL), .DIR_SETUP(DS), .DIR_HOLD(DH), .STP_INV(1'b0), .DIR_INV(1'b0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .jointEnable(en), .jointFreqCmd(cmd),
      .jointFeedback(fb), .jointBusy(busy), .DIR(dir), .STP(stp)
   );

   joint_stepper_timed #(
      .WIDTH(32), .PULSE_LEN(PL), .DIR_SETUP(DS), .DIR_HOLD(DH), .STP_INV(1'b1), .DIR_INV(1'b1)
   ) dut_inv (
      .clk(clk), .rst_n(rst_n), .jointEnable(en), .jointFreqCmd(cmd),
      .jointFeedback(fb_i), .jointBusy(busy_i), .DIR(dir_i), .STP(stp_i)
   );

   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- timeline model ----------------
   typedef enum int {MIdle, MSetup, MPeriod} mmode_t;
   mmode_t      m_mode;
   longint      n, m_start, m_T, m_setup_end;
   bit          m_dir;
   logic [31:0] m_fb;

   function automatic longint period_of(input logic signed [31:0] c);
      longint m;
      m = (c < 0) ? -longint'(c) : longint'(c);
      if (m > 64'sd2147483647) m = 64'sd2147483647;
      if (m < PL + DH) m = PL + DH;
      return m;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n      = 0;
         m_mode = MIdle;
         m_dir  = 1'b0;
         m_fb   = '0;
      end else begin : model_step
         bit decide, start, want;
         decide = 1'b0;
         start  = 1'b0;
         want   = (cmd > 0);
         n++;
         case (m_mode)
            MIdle: decide = 1'b1;
            MSetup: begin
               if (!en || cmd == 0) m_mode = MIdle;
               else if (want != m_dir) begin
                  m_dir       = want;
                  m_setup_end = n + DS;
               end else if (n == m_setup_end) start = 1'b1;
            end
            default: begin
               if (n == m_start + m_T || (!en && n >= m_start + PL + DH)) decide = 1'b1;
            end
         endcase
         if (decide) begin
            if (!en || cmd == 0) m_mode = MIdle;
            else if (want == m_dir) start = 1'b1;
            else begin
               m_dir       = want;
               m_mode      = MSetup;
               m_setup_end = n + DS;
            end
         end
         if (start) begin
            m_mode  = MPeriod;
            m_start = n;
            m_T     = period_of(cmd);
            m_fb    = m_dir ? m_fb + 32'd1 : m_fb - 32'd1;
         end
      end
   end

   always @(negedge clk) begin
      if (checking) begin : cmp
         logic e_stp;
         e_stp = (m_mode == MPeriod) && (n - m_start < PL);
         check("cyc_stp", {31'b0, stp}, {31'b0, e_stp});
         check("cyc_dir", {31'b0, dir}, {31'b0, m_dir});
         check("cyc_fb", fb, m_fb);
         check("cyc_busy", {31'b0, busy}, {31'b0, m_mode != MIdle});
         check("cyc_stp_inv", {31'b0, stp_i}, {31'b0, ~e_stp});
         check("cyc_dir_inv", {31'b0, dir_i}, {31'b0, ~m_dir});
      end
   end

   // ---------------- directed helpers ----------------
   task automatic go_idle();
      int c;
      @(negedge clk);
      en = 1'b0;
      c = 0;
      while (busy && c < 40) begin
         @(negedge clk);
         c++;
      end
      check("idle_reached", {31'b0, busy}, 32'd0);
   endtask

   // Counts clock edges from a rising STP to the next rising STP.
   task automatic measure_period(output int cycles);
      logic prev;
      prev   = 1'b1;
      cycles = 0;
      while (cycles < 40) begin
         @(posedge clk);
         #1;
         cycles++;
         if (stp && !prev) break;
         prev = stp;
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int          per;
      logic [7:0]  pat;
      logic [15:0] dir_h, stp_h, busy_h;
      logic [31:0] fb_h12;
      logic        any_stp;

      // 1. asynchronous reset, no clock edges
      #2 rst_n = 1'b0;
      #1;
      check("rst_stp", {31'b0, stp}, 32'd0);
      check("rst_dir", {31'b0, dir}, 32'd0);
      check("rst_fb", fb, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_stp_inv", {31'b0, stp_i}, 32'd1);
      check("rst_dir_inv", {31'b0, dir_i}, 32'd1);
      #2 rst_n = 1'b1;
      checking = 1'b1;
      clk_run  = 1'b1;
      repeat (3) @(negedge clk);

      // 2. +10 from reset: DIR next cycle, STP 3 cycles later, period 10
      en  = 1'b1;
      cmd = 32'sd10;
      @(posedge clk); #1;
      check("t2_dir_next", {31'b0, dir}, 32'd1);
      check("t2_stp_wait", {31'b0, stp}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("t2_stp_setup", {31'b0, stp}, 32'd0);
      @(posedge clk); #1;
      check("t2_stp_rise", {31'b0, stp}, 32'd1);
      check("t2_fb_first", fb, 32'd1);
      for (int i = 0; i < 4; i++) begin
         measure_period(per);
         check("t2_period", per, 32'd10);
      end
      check("t2_fb_five", fb, 32'd5);
      go_idle();

      // 3. +1 clamps to period 4: 1100 repeating
      @(negedge clk);
      cmd = 32'sd1;
      en  = 1'b1;
      pat = '0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         pat = {pat[6:0], stp};
      end
      check("t3_pattern", {24'b0, pat}, 32'h0000_00cc);
      check("t3_fb", fb, 32'd7);
      go_idle();

      // 4. +10 -> -10 during a pulse
      @(negedge clk);
      cmd = 32'sd10;
      en  = 1'b1;
      @(posedge clk); #1;
      check("t4_stp_start", {31'b0, stp}, 32'd1);
      check("t4_fb_up", fb, 32'd8);
      cmd = -32'sd10;
      fb_h12 = '0;
      dir_h = '0; stp_h = '0;
      for (int i = 1; i <= 14; i++) begin
         @(posedge clk); #1;
         dir_h[i] = dir;
         stp_h[i] = stp;
         if (i == 12) fb_h12 = fb;
      end
      check("t4_stp_full", {31'b0, stp_h[1]}, 32'd1);
      check("t4_stp_fall", {31'b0, stp_h[2]}, 32'd0);
      check("t4_dir_held", {31'b0, dir_h[9]}, 32'd1);
      check("t4_dir_fall", {31'b0, dir_h[10]}, 32'd0);
      check("t4_stp_setup", {31'b0, stp_h[12]}, 32'd0);
      check("t4_stp_rise", {31'b0, stp_h[13]}, 32'd1);
      check("t4_fb_before", fb_h12, 32'd8);
      check("t4_fb_down", fb, 32'd7);
      go_idle();

      // 5. enable drops in the first pulse cycle
      @(negedge clk);
      cmd = -32'sd10;
      en  = 1'b1;
      @(posedge clk); #1;
      en = 1'b0;
      busy_h = '0; stp_h = '0;
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk); #1;
         stp_h[i]  = stp;
         busy_h[i] = busy;
      end
      check("t5_stp_full", {31'b0, stp_h[1]}, 32'd1);
      check("t5_stp_fall", {31'b0, stp_h[2]}, 32'd0);
      check("t5_busy_hold", {31'b0, busy_h[3]}, 32'd1);
      check("t5_busy_idle", {31'b0, busy_h[4]}, 32'd0);
      any_stp = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         any_stp |= stp;
      end
      check("t5_no_pulses", {31'b0, any_stp}, 32'd0);
      check("t5_fb", fb, 32'd6);

      // 6. most negative command, then reset mid-pulse
      @(posedge clk);
      #3 rst_n = 1'b0;
      #4 rst_n = 1'b1;
      @(negedge clk);
      cmd = 32'sh8000_0000;
      en  = 1'b1;
      @(posedge clk); #1;
      check("t6_stp", {31'b0, stp}, 32'd1);
      check("t6_dir", {31'b0, dir}, 32'd0);
      check("t6_fb", fb, 32'hffff_ffff);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_stp", {31'b0, stp}, 32'd0);
      check("t6_rst_fb", fb, 32'd0);
      check("t6_rst_busy", {31'b0, busy}, 32'd0);
      check("t6_rst_stp_inv", {31'b0, stp_i}, 32'd1);
      en = 1'b0;
      #1 rst_n = 1'b1;
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
